run_filter: RTL and testbench
=============================

# run_filter

Multi-channel, parametrised run-length qualifier. It is the generalised successor of the two-consecutive-highs detector. Each channel's output rises only after an input has been high for RISE_LEN consecutive sampled cycles, and falls only after FALL_LEN consecutive low samples. The block also provides per-channel edge pulses, a sampling enable and a count of asserted channels. It sits between raw synchronous status/button inputs and downstream control logic, acting as a qualifier/debouncer.

## Interface
- CHANNELS, 4, number of independent channels (>= 1)
- RISE_LEN, 2, consecutive 1-samples required to assert a channel (>= 1)
- FALL_LEN, 1, consecutive 0-samples required to deassert a channel (>= 1)
- CW (derived, not overridable), $clog2(max(RISE_LEN,FALL_LEN)+1), run counter width
- clk  input  1  sole clock; all sampling on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = sample data_in this edge; 0 = freeze all state
- data_in  input  CHANNELS  raw per-channel inputs, already synchronous to clk
- run_out  output  CHANNELS  qualified level per channel, registered
- rise_pulse  output  CHANNELS  1-cycle pulse, registered, on the edge a channel asserts
- fall_pulse  output  CHANNELS  1-cycle pulse, registered, on the edge a channel deasserts
- active_count  output  $clog2(CHANNELS+1)  number of run_out bits currently 1

## Operation
- Per channel, two registers:
  - level: drives run_out.
  - cnt (CW bits): consecutive samples that disagree with level.
- Threshold: T = RISE_LEN when level = 0; T = FALL_LEN when level = 1.
- Each rising clk edge, per channel, priority order:
  - reset = 1: level <= 0, cnt <= 0, rise_pulse <= 0, fall_pulse <= 0.
  - enable = 0: level and cnt hold; both pulses <= 0.
  - data_in == level: cnt <= 0; pulses <= 0.
  - data_in != level and cnt + 1 == T: level <= ~level, cnt <= 0; rise_pulse <= 1 if the new level is 1, else fall_pulse <= 1.
  - data_in != level and cnt + 1 < T: cnt <= cnt + 1; pulses <= 0.
- cnt never exceeds T-1; there is no wrap-around path.
- A single agreeing sample restarts the run. Example: with RISE_LEN = 2, input 1,0,1,0 never asserts.
- Channels are fully independent. There is no cross-channel state except active_count.
- active_count is a combinational population count of the registered run_out.
  - It is glitch-free relative to clk.
  - It changes on the same cycle as run_out.
  - Range is 0..CHANNELS; width is sized so CHANNELS itself is representable.
- With RISE_LEN = 2 and FALL_LEN = 1, a single channel is behaviourally identical to the predecessor two-high detector.

## Timing
- Reset values: run_out = 0, rise_pulse = 0, fall_pulse = 0, active_count = 0, all cnt = 0.
- Assert latency: input high and enable = 1 from sample k onward gives run_out = 1 after edge k + RISE_LEN - 1.
  - Counting starts at the first edge that samples 1.
  - RISE_LEN = 1 gives a plain one-cycle registered delay.
- Deassert latency: symmetric, using FALL_LEN.
- rise_pulse and fall_pulse are high for exactly the one cycle following the edge on which level toggled. They are never both high on one channel.
- Enable-low cycles are invisible to the counter: the run neither advances nor breaks. After enable returns, counting resumes from the held cnt.
- Reset mid-run: on the edge after reset = 1, all outputs are 0 and counts restart from 0. A channel held at 1 through reset re-asserts RISE_LEN edges after reset deasserts.
- Reset asserted together with enable/data: reset wins.
- Threshold reached on the same edge enable = 0: no toggle, since the sample is ignored.

## Test plan
- Defaults (4, 2, 1): data_in[0] 0 → 1 at a negedge. Expect:
  - run_out[0] = 0 after edge 1.
  - run_out[0] = 1 after edge 2, with rise_pulse[0] = 1 for that one cycle.
  - data_in[0] → 0: run_out[0] = 0 after one edge, with fall_pulse[0] = 1.
- Defaults: data_in[1] toggles 1,0,1,0,1,0 each cycle → run_out[1] stays 0 and rise_pulse[1] is never set.
- RISE_LEN = 3, FALL_LEN = 3, channel asserted: feed 0,0,1,0,0,0 → run_out stays 1 through the 1 and falls only after the third trailing 0.
- Defaults: data_in[2] = 1 for one edge, enable = 0 for 5 cycles, then enable = 1 → run_out[2] = 1 after the first enabled edge. No pulses while enable = 0.
- Defaults, run_out[3] = 1: hold data_in[3] = 1, pulse reset for one edge → run_out[3] = 0 next cycle, returns to 1 two edges after reset drops.
- Defaults: data_in = 4'b1111 for 2 edges → active_count = 4 on the same cycle run_out = 4'b1111. Then data_in = 4'b0101 → active_count = 2 after one edge.

Source files
------------

// File: rtl/run_filter_if.sv
// Handshake/bus bundle for run_filter: raw sampled inputs toward the qualifier,
// qualified levels, edge pulses and population count back from it.
interface run_filter_if #(
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned AW = $clog2(CHANNELS + 1);

    logic                enable;
    logic [CHANNELS-1:0] data_in;
    logic [CHANNELS-1:0] run_out;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;
    logic [AW-1:0]       active_count;

    modport master (
        output enable,
        output data_in,
        input  run_out,
        input  rise_pulse,
        input  fall_pulse,
        input  active_count
    );

    modport slave (
        input  enable,
        input  data_in,
        output run_out,
        output rise_pulse,
        output fall_pulse,
        output active_count
    );
endinterface

// File: rtl/run_filter.sv
// Multi-channel run-length qualifier: a channel asserts after RISE_LEN consecutive
// high samples and deasserts after FALL_LEN consecutive low samples.
module run_filter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RISE_LEN = 2,
    parameter int unsigned FALL_LEN = 1
) (
    input  logic         clk,
    input  logic         reset,
    run_filter_if.slave  bus
);
    localparam int unsigned MAX_LEN = (RISE_LEN > FALL_LEN) ? RISE_LEN : FALL_LEN;
    localparam int unsigned CW      = $clog2(MAX_LEN + 1);
    localparam int unsigned AW      = $clog2(CHANNELS + 1);

    // Thresholds carry one extra bit so cnt+1 never overflows before comparison.
    localparam logic [CW:0] RISE_T = RISE_LEN[CW:0];
    localparam logic [CW:0] FALL_T = FALL_LEN[CW:0];

    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CW:0]         thr;
    logic [CW:0]         nxt;
    logic [AW-1:0]       count;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        thr     = '0;
        nxt     = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            thr      = level_q[i] ? FALL_T : RISE_T;
            nxt      = {1'b0, cnt_q[i]} + 1'b1;
            if (bus.enable) begin
                if (bus.data_in[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (nxt == thr) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = ~level_q[i];
                    fall_d[i]  = level_q[i];
                end else begin
                    cnt_d[i] = nxt[CW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    // Population count of registered levels, so it settles with run_out.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            count = count + AW'(level_q[i]);
        end
    end

    assign bus.run_out      = level_q;
    assign bus.rise_pulse   = rise_q;
    assign bus.fall_pulse   = fall_q;
    assign bus.active_count = count;
endmodule

// File: tb/tb_run_filter.sv
// Directed bench for run_filter: default-parameter vector table plus a
// hand-written sequence on a RISE_LEN=3/FALL_LEN=3 instance.
module tb_run_filter;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    run_filter_if #(.CHANNELS(4)) if_a ();
    run_filter_if #(.CHANNELS(1)) if_b ();

    run_filter #(.CHANNELS(4), .RISE_LEN(2), .FALL_LEN(1)) u_a (
        .clk   (clk),
        .reset (rst),
        .bus   (if_a.slave)
    );

    run_filter #(.CHANNELS(1), .RISE_LEN(3), .FALL_LEN(3)) u_b (
        .clk   (clk),
        .reset (rst),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [3:0] din;
        logic [3:0] exp_run;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic r, input logic e, input logic [3:0] d,
                       input logic [3:0] er, input logic [3:0] eu, input logic [3:0] ef,
                       input logic [2:0] ec);
        vec_t v;
        v.name = n; v.rst = r; v.en = e; v.din = d;
        v.exp_run = er; v.exp_rise = eu; v.exp_fall = ef; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    logic       b_in  [9];
    logic       b_run [9];
    logic       b_rise[9];
    logic       b_fall[9];

    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        if_a.enable  = 1'b1;
        if_a.data_in = 4'b1111;
        if_b.enable  = 1'b1;
        if_b.data_in = 1'b1;

        //   name           rst en  din      run      rise     fall     cnt
        add("reset_wins",   1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch0_first",    0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch0_assert",   0, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 3'd1);
        add("ch0_fall",     0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 3'd0);
        add("ch1_tog1",     0, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch1_tog0",     0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch1_tog1b",    0, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch1_tog0b",    0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch1_tog1c",    0, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch1_tog0c",    0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch2_first",    0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch2_hold0",    0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch2_hold1",    0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch2_hold2",    0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch2_hold3",    0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch2_hold4",    0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch2_resume",   0, 1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 3'd1);
        add("ch2_steady",   0, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 3'd1);
        add("all_first",    0, 1, 4'b1111, 4'b0100, 4'b0000, 4'b0000, 3'd1);
        add("all_assert",   0, 1, 4'b1111, 4'b1111, 4'b1011, 4'b0000, 3'd4);
        add("pat_0101",     0, 1, 4'b0101, 4'b0101, 4'b0000, 4'b1010, 3'd2);
        add("ch3_first",    0, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0101, 3'd0);
        add("ch3_assert",   0, 1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 3'd1);
        add("ch3_reset",    1, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch3_restart",  0, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 3'd0);
        add("ch3_reassert", 0, 1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 3'd1);
        add("thr_first",    0, 1, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 3'd1);
        add("thr_frozen",   0, 0, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 3'd1);
        add("thr_resume",   0, 1, 4'b1001, 4'b1001, 4'b0001, 4'b0000, 3'd2);
        add("rst_en_low",   1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 3'd0);

        foreach (vecs[k]) begin
            rst          = vecs[k].rst;
            if_a.enable  = vecs[k].en;
            if_a.data_in = vecs[k].din;
            step();
            check({vecs[k].name, ".run"},   32'(if_a.run_out),      32'(vecs[k].exp_run));
            check({vecs[k].name, ".rise"},  32'(if_a.rise_pulse),   32'(vecs[k].exp_rise));
            check({vecs[k].name, ".fall"},  32'(if_a.fall_pulse),   32'(vecs[k].exp_fall));
            check({vecs[k].name, ".count"}, 32'(if_a.active_count), 32'(vecs[k].exp_cnt));
        end

        // RISE_LEN=3/FALL_LEN=3 instance: assert after three 1s, then 0,0,1,0,0,0.
        rst = 1'b1;
        if_a.enable = 1'b0;
        if_b.data_in = 1'b1;
        step();
        check("b_reset.run", 32'(if_b.run_out), 32'd0);
        rst = 1'b0;
        b_in   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        b_run  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        b_rise = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        b_fall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            if_b.enable  = 1'b1;
            if_b.data_in = b_in[i];
            step();
            check($sformatf("b_seq%0d.run", i),  32'(if_b.run_out),    32'(b_run[i]));
            check($sformatf("b_seq%0d.rise", i), 32'(if_b.rise_pulse), 32'(b_rise[i]));
            check($sformatf("b_seq%0d.fall", i), 32'(if_b.fall_pulse), 32'(b_fall[i]));
            check($sformatf("b_seq%0d.count", i), 32'(if_b.active_count), 32'(b_run[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
